// File: rtl/bcd_pkg.sv
// Shared types and constants for the 16-bit binary to 5-digit BCD converter.
package bcd_pkg;

   localparam int unsigned WIDTH_DEF  = 16;
   localparam int unsigned DIGITS_DEF = 5;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned ADJ_THRESH = 5;
   localparam int unsigned ADJ_VALUE  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : bcd_pkg

// File: rtl/bin16_to_bcd_if.sv
// Result handshake between the upstream scaler and the BCD converter.
interface bin16_to_bcd_if #(
   parameter int unsigned WIDTH  = bcd_pkg::WIDTH_DEF,
   parameter int unsigned DIGITS = bcd_pkg::DIGITS_DEF
);

   logic                  valid_i;
   logic [WIDTH-1:0]      data_i;
   logic                  ready_o;
   logic [4*DIGITS-1:0]   bcd_o;
   logic                  done_o;

   modport master (
      output valid_i,
      output data_i,
      input  ready_o,
      input  bcd_o,
      input  done_o
   );

   modport slave (
      input  valid_i,
      input  data_i,
      output ready_o,
      output bcd_o,
      output done_o
   );

endinterface : bin16_to_bcd_if

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_digit,
   output logic [DIGIT_W-1:0] o_digit_c
);

   // 4-bit add; a digit of at most 9 never carries out of its nibble
   always_comb begin
      o_digit_c = i_digit;
      if (i_digit >= DIGIT_W'(ADJ_THRESH)) begin
         o_digit_c = i_digit + DIGIT_W'(ADJ_VALUE);
      end
   end

endmodule : bcd_digit_adj

// File: rtl/bin16_to_bcd.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock,
// started by a rising edge of valid_i, with a one-deep pending start.
module bin16_to_bcd
   import bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   bin16_to_bcd_if.slave bus
);

   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned      BCD_W    = DIGIT_W * DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             r_state;
   logic               r_valid_q;
   logic               r_pend_q;
   logic [WIDTH-1:0]   r_shift;
   logic [BCD_W-1:0]   r_work;
   logic [CNT_W-1:0]   r_cnt;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_done;

   state_e             w_state_nxt;
   logic               w_pend_nxt;
   logic [WIDTH-1:0]   w_shift_nxt;
   logic [BCD_W-1:0]   w_work_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [BCD_W-1:0]   w_bcd_nxt;
   logic               w_done_nxt;

   logic [BCD_W-1:0]   w_adj;
   logic               w_rise;
   logic               w_unused_msb;

   // Per-digit add-3 correction on the working BCD register
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit   (r_work[DIGIT_W*g +: DIGIT_W]),
         .o_digit_c (w_adj[DIGIT_W*g +: DIGIT_W])
      );
   end

   // The top bit shifts out of the working register and is discarded
   assign w_unused_msb = w_adj[BCD_W-1];

   assign w_rise = bus.valid_i & ~r_valid_q;

   // Next-state and datapath decode
   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend_q;
      w_shift_nxt = r_shift;
      w_work_nxt  = r_work;
      w_cnt_nxt   = r_cnt;
      w_bcd_nxt   = r_bcd;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_rise || r_pend_q) begin
               w_shift_nxt = bus.data_i;
               w_work_nxt  = '0;
               w_cnt_nxt   = '0;
               w_pend_nxt  = 1'b0;
               w_state_nxt = SHIFT;
            end
         end

         SHIFT: begin
            if (w_rise) begin
               w_pend_nxt = 1'b1;
            end
            {w_work_nxt, w_shift_nxt} = {w_adj[BCD_W-2:0], r_shift, 1'b0};
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         DONE: begin
            if (w_rise) begin
               w_pend_nxt = 1'b1;
            end
            w_bcd_nxt   = r_work;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, edge detector and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_valid_q <= 1'b0;
         r_pend_q  <= 1'b0;
         r_shift   <= '0;
         r_work    <= '0;
         r_cnt     <= '0;
         r_bcd     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_valid_q <= bus.valid_i;
         r_pend_q  <= w_pend_nxt;
         r_shift   <= w_shift_nxt;
         r_work    <= w_work_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bcd     <= w_bcd_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign bus.ready_o = (r_state == IDLE);
   assign bus.bcd_o   = r_bcd;
   assign bus.done_o  = r_done;

endmodule : bin16_to_bcd

// File: tb/tb_bin16_to_bcd.sv
// Self-checking bench for bin16_to_bcd: directed scenarios plus random
// conversions, all compared against a decimal-arithmetic timing model.
module tb_bin16_to_bcd;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned DIGITS  = 5;
   localparam int unsigned LATENCY = WIDTH + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   bin16_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   bin16_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Reference decimal conversion
   function automatic logic [19:0] to_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Timing model: a busy countdown, a one-deep pending flag, decimal result
   logic        m_prev  = 1'b0;
   logic        m_pend  = 1'b0;
   int          m_busy  = 0;
   logic [15:0] m_data  = '0;
   logic [19:0] m_bcd   = '0;
   logic        m_done  = 1'b0;
   logic        m_rise;

   assign m_rise = bus.valid_i & ~m_prev;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev <= 1'b0;
         m_pend <= 1'b0;
         m_busy <= 0;
         m_data <= '0;
         m_bcd  <= '0;
         m_done <= 1'b0;
      end else begin
         m_prev <= bus.valid_i;
         m_done <= 1'b0;
         if (m_busy == 0) begin
            if (m_rise || m_pend) begin
               m_data <= bus.data_i;
               m_pend <= 1'b0;
               m_busy <= LATENCY;
            end
         end else begin
            if (m_rise) m_pend <= 1'b1;
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
               m_done <= 1'b1;
               m_bcd  <= to_bcd(32'(m_data));
            end
         end
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      check("ready_o", 32'(bus.ready_o), 32'(m_busy == 0));
      check("done_o",  32'(bus.done_o),  32'(m_done));
      check("bcd_o",   32'(bus.bcd_o),   32'(m_bcd));
   end

   // One isolated conversion with latency, ready and literal result checks
   task automatic convert(input logic [15:0] d, input logic [19:0] exp, input string name);
      int n;
      int rdy_low;
      @(posedge clk); #1;
      bus.data_i  = d;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      n = 0;
      rdy_low = bus.ready_o ? 0 : 1;
      while (!bus.done_o && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (!bus.ready_o) rdy_low++;
      end
      check({name, "_latency"}, 32'(n), 32'(LATENCY));
      check({name, "_bcd"}, 32'(bus.bcd_o), 32'(exp));
      check({name, "_ready_low"}, 32'(rdy_low), 32'(LATENCY));
   endtask

   initial begin
      int n;
      int pulses;
      int second_at;

      bus.valid_i = 1'b0;
      bus.data_i  = '0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready_o), 32'd1);
      check("rst_done",  32'(bus.done_o),  32'd0);
      check("rst_bcd",   32'(bus.bcd_o),   32'h0);
      rst_n = 1'b1;

      // Directed values including the maximum
      convert(16'hFFFF, 20'h65535, "max");
      convert(16'd0,    20'h00000, "zero");
      convert(16'd256,  20'h00256, "d256");
      convert(16'd9999, 20'h09999, "d9999");

      // valid_i held high for 40 cycles gives exactly one conversion
      @(posedge clk); #1;
      bus.data_i  = 16'd1234;
      bus.valid_i = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done_o) pulses++;
      end
      bus.valid_i = 1'b0;
      check("held_pulses", 32'(pulses), 32'd1);
      check("held_bcd", 32'(bus.bcd_o), 32'h01234);

      // A rise during SHIFT is queued and starts on the first IDLE edge
      @(posedge clk); #1;
      bus.data_i  = 16'd777;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      n = 0;
      pulses = 0;
      second_at = 0;
      while (pulses < 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (n == 5)  bus.valid_i = 1'b1;
         if (n == 10) bus.data_i  = 16'd42;
         if (bus.done_o) begin
            pulses++;
            if (pulses == 1) check("pend_first_bcd", 32'(bus.bcd_o), 32'h00777);
            if (pulses == 2) second_at = n;
         end
      end
      bus.valid_i = 1'b0;
      check("pend_pulses", 32'(pulses), 32'd2);
      check("pend_second_done_edge", 32'(second_at), 32'(18 + LATENCY));
      check("pend_second_bcd", 32'(bus.bcd_o), 32'h00042);

      // Reset mid-conversion, released with valid_i still high
      @(posedge clk); #1;
      bus.data_i  = 16'd9999;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n       = 1'b0;
      bus.valid_i = 1'b1;
      bus.data_i  = 16'd500;
      #1;
      check("rst_mid_bcd", 32'(bus.bcd_o), 32'h0);
      check("rst_mid_ready", 32'(bus.ready_o), 32'd1);
      pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.done_o) pulses++;
      end
      check("rst_mid_no_done", 32'(pulses), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_restart_busy", 32'(bus.ready_o), 32'd0);
      n = 0;
      while (!bus.done_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_restart_latency", 32'(n), 32'(LATENCY));
      check("rst_restart_bcd", 32'(bus.bcd_o), 32'h00500);
      bus.valid_i = 1'b0;

      // Random data and valid_i patterns, checked by the model every cycle
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         bus.data_i  = 16'($urandom);
         bus.valid_i = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
         bus.valid_i = 1'b0;
         bus.data_i  = 16'($urandom);
         repeat ($urandom_range(0, 22)) @(posedge clk);
      end
      repeat (2 * LATENCY + 4) @(posedge clk);
      #1;
      check("final_ready", 32'(bus.ready_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_bin16_to_bcd
